dual_client_ram_arbiter: RTL and testbench
==========================================

DUAL_CLIENT_RAM_ARBITER -- requirements
Module: dual_client_ram_arbiter

Interface
REQ-001 Parameter: length, default 8, data word width in bits.
REQ-002 Parameter: locations, default 32, RAM depth; AW = $clog2(locations).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  client access request, held high until granted.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; valid while reqN is high.
REQ-007 addr0 / addr1  input  AW  client address.
REQ-008 wdata0 / wdata1  input  length  client write data.
REQ-009 gnt0 / gnt1  output  1  request accepted at the coming posedge (combinational).
REQ-010 rvalid0 / rvalid1  output  1  registered one-cycle pulse: rdataN holds read result.
REQ-011 rdata0 / rdata1  output  length  registered read data per client.
REQ-012 ram_rw  output  1  RAM command: 1 = write, 0 = read.
REQ-013 ram_w_addr, ram_r_addr  output  AW  RAM write and read addresses.
REQ-014 ram_indata  output  length  RAM write data.
REQ-015 ram_outdata  input  length  RAM read data, valid the cycle after a read is issued.

Function
REQ-016 At most one grant per cycle; gnt0 & gnt1 SHALL never both be 1.
REQ-017 Only one requester high: that requester is granted in the same cycle.
REQ-018 Both requesters high: grant goes to the client named by the 1-bit priority pointer ptr.
REQ-019 After any grant to client N, ptr <= other client (round-robin); with no grant, ptr holds.
REQ-020 Granted client's we/addr/wdata drive the RAM combinationally: ram_rw = weN, ram_w_addr = ram_r_addr = addrN, ram_indata = wdataN.
REQ-021 No grant: ram_rw = 0, addresses = 0, ram_indata = 0 (idle read, result discarded).
REQ-022 Granted read at cycle T: rvalidN = 1 and rdataN = ram_outdata in cycle T+2 (1 cycle RAM, 1 cycle output register); otherwise rvalidN = 0.
REQ-023 rdataN holds its last value when rvalidN = 0.
REQ-024 Writes produce no rvalid pulse; the write commits at the grant edge.
REQ-025 Back-to-back reads issue every cycle; the read tag pipeline (valid + client id) SHALL sustain 1 read per cycle with no bubbles.
REQ-026 Ordering: same-address write then read, granted in consecutive cycles, SHALL return the new data (RAM write-before-read across edges).
REQ-027 A continuously requesting client SHALL wait at most 1 cycle between grants (no starvation).

Reset
REQ-028 While rst = 1 at posedge: ptr <= 0 (client 0 priority), read-tag pipeline cleared, rvalid0/1 <= 0, rdata0/1 <= 0.
REQ-029 Grants SHALL be suppressed (gnt0 = gnt1 = 0, RAM idle per REQ-021) while rst = 1.
REQ-030 Reset mid-operation: in-flight read results SHALL be dropped; no rvalid pulse after reset deasserts for pre-reset reads.

Structure
REQ-031 length/locations defaults and the RW_WRITE/RW_READ encodings SHALL live in the shared memory-constants include, used by this block and the RAM.
REQ-032 Two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (req[1:0], ptr in, gnt[1:0] out); pointer register stays in the parent.
REQ-033 The RAM is NOT instantiated inside; the bench connects dual_client_ram_arbiter to simple_dual_port_ram.

Verification
REQ-034 Reset, then req0 writes 8'hA5 to addr 3, then reads addr 3 -> gnt0 each cycle, rvalid0 pulse 2 cycles after read grant, rdata0 = 8'hA5.
REQ-035 req0 and req1 both held for 6 cycles after reset -> grants 0,1,0,1,0,1; never simultaneous.
REQ-036 Client0 writes 8'h11 to addr 7, client1 reads addr 7 in the next grant -> rdata1 = 8'h11, rvalid0 never pulses.
REQ-037 Both clients stream reads of addresses 0..31 after prefill with addr^8'h3C -> every rvalid carries the correct data for its own client, one result per cycle.
REQ-038 Assert rst for 1 cycle while two reads in flight -> no rvalid after reset, ptr = 0, next contested grant goes to client 0.
REQ-039 Idle 5 cycles (no req) -> gnt0 = gnt1 = 0, ram_rw = 0, rvalid0 = rvalid1 = 0, ptr unchanged.

Source files
------------

// File: rtl/dual_client_ram_arbiter_pkg.sv
// Shared memory constants and types for the dual-client RAM arbiter and the
// simple dual-port RAM it drives.
//   MEM_LENGTH     default data word width in bits
//   MEM_LOCATIONS  default RAM depth in words
//   RW_WRITE/READ  encoding of the ram_rw command
//   client_e       client identifier, also used as the round-robin pointer
//   rd_tag_t       read-tag carried alongside an outstanding RAM read
package dual_client_ram_arbiter_pkg;

  localparam int unsigned MEM_LENGTH    = 8;
  localparam int unsigned MEM_LOCATIONS = 32;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic {
    Client0 = 1'b0,
    Client1 = 1'b1
  } client_e;

  typedef struct packed {
    logic    valid;
    client_e id;
  } rd_tag_t;

  function automatic client_e other_client(input client_e c);
    return (c == Client0) ? Client1 : Client0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational.
//   req_i  request vector, bit N = client N
//   ptr_i  priority pointer: client that wins when both request
//   gnt_o  one-hot (or zero) grant vector
// The pointer register itself lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM with one shared command bit.
//   clk_i      clock
//   rw_i       1 = write indata_i to w_addr_i at the edge, 0 = read
//   w_addr_i   write address
//   r_addr_i   read address
//   indata_i   write data
//   outdata_o  registered read data, valid the cycle after the read is issued
// A write commits at the edge, so a read issued in the following cycle sees it.
module simple_dual_port_ram
  import dual_client_ram_arbiter_pkg::*;
#(
  parameter int unsigned length    = MEM_LENGTH,
  parameter int unsigned locations = MEM_LOCATIONS,
  localparam int unsigned AW       = $clog2(locations)
) (
  input  logic              clk_i,
  input  logic              rw_i,
  input  logic [AW-1:0]     w_addr_i,
  input  logic [AW-1:0]     r_addr_i,
  input  logic [length-1:0] indata_i,
  output logic [length-1:0] outdata_o
);

  logic [length-1:0] mem_q [locations];
  logic [length-1:0] outdata_q;

  always_ff @(posedge clk_i) begin
    if (rw_i == RW_WRITE) begin
      mem_q[w_addr_i] <= indata_i;
    end
    outdata_q <= mem_q[r_addr_i];
  end

  assign outdata_o = outdata_q;

endmodule

// File: rtl/dual_client_ram_arbiter.sv
// Arbitrates two clients onto a single-command dual-port RAM.
//   clk, rst            clock and synchronous active-high reset
//   req/we/addr/wdataN  client N request, direction, address, write data
//   gntN                combinational grant: request is taken at the next edge
//   rvalidN, rdataN     registered read result for client N (one-cycle pulse)
//   ram_*               RAM command, addresses and write data (combinational)
//   ram_outdata         RAM read data, valid the cycle after a read is issued
// A granted read at cycle T returns on rvalidN/rdataN in cycle T+2: one cycle
// in the RAM, one in the output register. A one-entry tag follows each read so
// the returning data is steered to the right client at full throughput.
module dual_client_ram_arbiter
  import dual_client_ram_arbiter_pkg::*;
#(
  parameter int unsigned length    = MEM_LENGTH,
  parameter int unsigned locations = MEM_LOCATIONS,
  localparam int unsigned AW       = $clog2(locations)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AW-1:0]     addr0,
  input  logic [AW-1:0]     addr1,
  input  logic [length-1:0] wdata0,
  input  logic [length-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [length-1:0] rdata0,
  output logic [length-1:0] rdata1,
  output logic              ram_rw,
  output logic [AW-1:0]     ram_w_addr,
  output logic [AW-1:0]     ram_r_addr,
  output logic [length-1:0] ram_indata,
  input  logic [length-1:0] ram_outdata
);

  logic [1:0]        req_v;
  logic [1:0]        gnt_v;
  client_e           gnt_id;
  logic              rd_issue;
  client_e           ptr_q, ptr_d;
  rd_tag_t           tag_q, tag_d;
  logic              rvalid0_q, rvalid1_q;
  logic [length-1:0] rdata0_q, rdata1_q;

  // Masking requests during reset keeps the RAM idle and the pointer still.
  assign req_v = rst ? 2'b00 : {req1, req0};

  rr_arbiter2 u_rr_arbiter2 (
    .req_i (req_v),
    .ptr_i (ptr_q),
    .gnt_o (gnt_v)
  );

  assign gnt0 = gnt_v[0];
  assign gnt1 = gnt_v[1];

  // Granted client drives the RAM; with no grant the RAM sees an idle read.
  always_comb begin
    ram_rw     = RW_READ;
    ram_w_addr = '0;
    ram_r_addr = '0;
    ram_indata = '0;
    gnt_id     = Client0;
    unique case (gnt_v)
      2'b01: begin
        ram_rw     = we0 ? RW_WRITE : RW_READ;
        ram_w_addr = addr0;
        ram_r_addr = addr0;
        ram_indata = wdata0;
        gnt_id     = Client0;
      end
      2'b10: begin
        ram_rw     = we1 ? RW_WRITE : RW_READ;
        ram_w_addr = addr1;
        ram_r_addr = addr1;
        ram_indata = wdata1;
        gnt_id     = Client1;
      end
      default: begin
        ram_rw = RW_READ;
      end
    endcase
  end

  assign rd_issue = (|gnt_v) && (ram_rw == RW_READ);

  always_comb begin
    tag_d.valid = rd_issue;
    tag_d.id    = gnt_id;
    ptr_d       = (|gnt_v) ? other_client(gnt_id) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= Client0;
      tag_q.valid <= 1'b0;
      tag_q.id    <= Client0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_q     <= tag_d;
      // tag_q describes the read whose data sits on ram_outdata this cycle.
      rvalid0_q <= tag_q.valid && (tag_q.id == Client0);
      rvalid1_q <= tag_q.valid && (tag_q.id == Client1);
      if (tag_q.valid && (tag_q.id == Client0)) begin
        rdata0_q <= ram_outdata;
      end
      if (tag_q.valid && (tag_q.id == Client1)) begin
        rdata1_q <= ram_outdata;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

  a_one_grant: assert property (@(posedge clk) !(gnt0 && gnt1));

endmodule

// File: tb/tb_dual_client_ram_arbiter.sv
module tb_dual_client_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_rw;
  logic [4:0] ram_w_addr, ram_r_addr;
  logic [7:0] ram_indata, ram_outdata;

  dual_client_ram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .ram_rw      (ram_rw),
    .ram_w_addr  (ram_w_addr),
    .ram_r_addr  (ram_r_addr),
    .ram_indata  (ram_indata),
    .ram_outdata (ram_outdata)
  );

  simple_dual_port_ram u_ram (
    .clk_i     (clk),
    .rw_i      (ram_rw),
    .w_addr_i  (ram_w_addr),
    .r_addr_i  (ram_r_addr),
    .indata_i  (ram_indata),
    .outdata_o (ram_outdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish before limit");
    $fatal(1);
  end

  // Reference model: memory image, priority pointer, list of read results
  // with the cycle at which each must appear.
  typedef struct {
    int         due;
    bit         cl;
    logic [7:0] d;
  } rd_t;

  logic [7:0] m_mem [32];
  logic [7:0] m_rd  [2];
  bit         m_ptr;
  rd_t        pend [$];
  int         cyc;

  bit         e_g0, e_g1, e_rv0, e_rv1, e_rw;
  logic [4:0] e_addr;
  logic [7:0] e_ind, e_rd0, e_rd1;

  int total;
  int bad;

  task automatic eval_model();
    rd_t r;
    e_rv0 = 1'b0;
    e_rv1 = 1'b0;
    while (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      m_rd[r.cl] = r.d;
      if (r.cl) e_rv1 = 1'b1;
      else e_rv0 = 1'b1;
    end
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        if (m_ptr) e_g1 = 1'b1;
        else e_g0 = 1'b1;
      end else if (req0) begin
        e_g0 = 1'b1;
      end else if (req1) begin
        e_g1 = 1'b1;
      end
    end
    e_rw   = e_g0 ? we0 : (e_g1 ? we1 : 1'b0);
    e_addr = e_g0 ? addr0 : (e_g1 ? addr1 : 5'd0);
    e_ind  = e_g0 ? (we0 ? wdata0 : wdata0) : (e_g1 ? wdata1 : 8'd0);
    e_rd0  = m_rd[0];
    e_rd1  = m_rd[1];
  endtask

  task automatic advance();
    rd_t r;
    @(posedge clk);
    if (rst) begin
      m_ptr = 1'b0;
      pend.delete();
      m_rd[0] = 8'd0;
      m_rd[1] = 8'd0;
    end else if (e_g0 || e_g1) begin
      if (e_rw) begin
        m_mem[e_addr] = e_ind;
      end else begin
        r.due = cyc + 2;
        r.cl  = e_g1;
        r.d   = m_mem[e_addr];
        pend.push_back(r);
      end
      m_ptr = e_g0;
    end
    cyc++;
    #1;
  endtask

  task automatic step(input bit r, input bit q0, input bit w0, input logic [4:0] a0,
                      input logic [7:0] d0, input bit q1, input bit w1,
                      input logic [4:0] a1, input logic [7:0] d1);
    rst    = r;
    req0   = q0;
    we0    = w0;
    addr0  = a0;
    wdata0 = d0;
    req1   = q1;
    we1    = w1;
    addr1  = a1;
    wdata1 = d1;
    #2;
    eval_model();
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 5'd1, 8'd0, 1'b1, 1'b0, 5'd2, 8'd0);
    advance();
    step(1'b1, 1'b1, 1'b1, 5'd1, 8'h55, 1'b1, 1'b0, 5'd2, 8'd0);
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_gnt: got %b%b required 00", gnt1, gnt0);
    end
    total++;
    if (ram_rw !== 1'b0 || ram_w_addr !== 5'd0 || ram_r_addr !== 5'd0 || ram_indata !== 8'd0) begin
      bad++;
      $display("FAIL reset_ram_idle: rw=%b wa=%0d ra=%0d in=%h required 0", ram_rw, ram_w_addr,
               ram_r_addr, ram_indata);
    end
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 8'd0 || rdata1 !== 8'd0) begin
      bad++;
      $display("FAIL reset_out: rv=%b%b rd0=%h rd1=%h required zeros", rvalid1, rvalid0, rdata0,
               rdata1);
    end
    advance();
  endtask

  task automatic test_prefill();
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 5'(a), 8'($urandom));
      total++;
      if (gnt1 !== e_g1 || gnt0 !== e_g0 || ram_rw !== e_rw || ram_w_addr !== e_addr) begin
        bad++;
        $display("FAIL prefill_gnt: a=%0d gnt=%b%b rw=%b wa=%0d required gnt=%b%b rw=%b wa=%0d",
                 a, gnt1, gnt0, ram_rw, ram_w_addr, e_g1, e_g0, e_rw, e_addr);
      end
      advance();
    end
  endtask

  task automatic test_write_read();
    step(1'b0, 1'b1, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0, 5'd0, 8'd0);
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_rw !== 1'b1 || ram_indata !== 8'hA5) begin
      bad++;
      $display("FAIL wr_grant: gnt=%b%b rw=%b in=%h required gnt=01 rw=1 in=a5", gnt1, gnt0,
               ram_rw, ram_indata);
    end
    advance();
    step(1'b0, 1'b1, 1'b0, 5'd3, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    total++;
    if (gnt0 !== 1'b1 || ram_rw !== 1'b0 || ram_r_addr !== 5'd3) begin
      bad++;
      $display("FAIL rd_grant: gnt0=%b rw=%b ra=%0d required 1 0 3", gnt0, ram_rw, ram_r_addr);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
      total++;
      if (rvalid0 !== (k == 1) || rvalid1 !== 1'b0) begin
        bad++;
        $display("FAIL rd_latency: k=%0d rvalid0=%b required %b", k, rvalid0, (k == 1));
      end
      if (k >= 1) begin
        total++;
        if (rdata0 !== 8'hA5) begin
          bad++;
          $display("FAIL rd_data: k=%0d rdata0=%h required a5", k, rdata0);
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    advance();
    for (int i = 0; i < 9; i++) begin
      if (i < 6) step(1'b0, 1'b1, 1'b0, 5'(i), 8'd0, 1'b1, 1'b0, 5'(i + 10), 8'd0);
      else step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
      total++;
      if (i < 6 && (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1))) begin
        bad++;
        $display("FAIL contention_gnt: i=%0d gnt=%b%b required %b%b", i, gnt1, gnt0,
                 (i % 2 == 1), (i % 2 == 0));
      end else if (i >= 6 && (gnt0 !== 1'b0 || gnt1 !== 1'b0)) begin
        bad++;
        $display("FAIL contention_idle: i=%0d gnt=%b%b required 00", i, gnt1, gnt0);
      end
      total++;
      if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1 || rdata0 !== e_rd0 || rdata1 !== e_rd1) begin
        bad++;
        $display("FAIL contention_rd: i=%0d rv=%b%b rd=%h/%h required rv=%b%b rd=%h/%h", i,
                 rvalid1, rvalid0, rdata1, rdata0, e_rv1, e_rv0, e_rd1, e_rd0);
      end
      advance();
    end
  endtask

  task automatic test_cross();
    step(1'b0, 1'b1, 1'b1, 5'd7, 8'h11, 1'b0, 1'b0, 5'd0, 8'd0);
    total++;
    if (gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL cross_wr_gnt: gnt0=%b required 1", gnt0);
    end
    advance();
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 5'd7, 8'd0);
    total++;
    if (gnt1 !== 1'b1 || ram_r_addr !== 5'd7) begin
      bad++;
      $display("FAIL cross_rd_gnt: gnt1=%b ra=%0d required 1 7", gnt1, ram_r_addr);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
      total++;
      if (rvalid0 !== 1'b0 || rvalid1 !== (k == 1)) begin
        bad++;
        $display("FAIL cross_rvalid: k=%0d rv=%b%b required %b0", k, rvalid1, rvalid0, (k == 1));
      end
      if (k == 1) begin
        total++;
        if (rdata1 !== 8'h11) begin
          bad++;
          $display("FAIL cross_data: rdata1=%h required 11", rdata1);
        end
      end
      advance();
    end
  endtask

  task automatic test_stream();
    int p0, p1, n;
    int res;
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b1, 1'b1, 5'(a), 8'(a) ^ 8'h3C, 1'b0, 1'b0, 5'd0, 8'd0);
      advance();
    end
    p0 = 0;
    p1 = 0;
    n = 0;
    res = 0;
    while ((p0 < 32 || p1 < 32 || pend.size() > 0) && n < 200) begin
      step(1'b0, p0 < 32, 1'b0, 5'(p0), 8'd0, p1 < 32, 1'b0, 5'(p1), 8'd0);
      total++;
      if (gnt0 !== e_g0 || gnt1 !== e_g1 || ram_rw !== e_rw || ram_r_addr !== e_addr) begin
        bad++;
        $display("FAIL stream_gnt: n=%0d gnt=%b%b rw=%b ra=%0d required gnt=%b%b rw=%b ra=%0d",
                 n, gnt1, gnt0, ram_rw, ram_r_addr, e_g1, e_g0, e_rw, e_addr);
      end
      total++;
      if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1 || rdata0 !== e_rd0 || rdata1 !== e_rd1) begin
        bad++;
        $display("FAIL stream_rd: n=%0d rv=%b%b rd=%h/%h required rv=%b%b rd=%h/%h", n,
                 rvalid1, rvalid0, rdata1, rdata0, e_rv1, e_rv0, e_rd1, e_rd0);
      end
      if (e_rv0 || e_rv1) res++;
      if (e_g0) p0++;
      if (e_g1) p1++;
      n++;
      advance();
    end
    // 64 reads granted back to back: results occupy cycles 2..65 with no gaps.
    total++;
    if (n != 66 || res != 64) begin
      bad++;
      $display("FAIL stream_rate: cycles=%0d results=%0d required 66 64", n, res);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    advance();
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 5'd2, 8'd0);
    advance();
    step(1'b1, 1'b1, 1'b0, 5'd4, 8'd0, 1'b1, 1'b0, 5'd5, 8'd0);
    total++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL midrst_gnt: gnt=%b%b required 00", gnt1, gnt0);
    end
    advance();
    step(1'b0, 1'b1, 1'b0, 5'd4, 8'd0, 1'b1, 1'b0, 5'd5, 8'd0);
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL midrst_first: gnt=%b%b required 01", gnt1, gnt0);
    end
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 8'd0 || rdata1 !== 8'd0) begin
      bad++;
      $display("FAIL midrst_drop0: rv=%b%b rd=%h/%h required zeros", rvalid1, rvalid0, rdata1,
               rdata0);
    end
    advance();
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      bad++;
      $display("FAIL midrst_drop1: rv=%b%b required 00", rvalid1, rvalid0);
    end
    advance();
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    total++;
    if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1 || rdata0 !== e_rd0) begin
      bad++;
      $display("FAIL midrst_post: rv=%b%b rd0=%h required rv=%b%b rd0=%h", rvalid1, rvalid0,
               rdata0, e_rv1, e_rv0, e_rd0);
    end
    advance();
  endtask

  task automatic test_random();
    bit r;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(39) == 0);
      step(r, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom), 5'($urandom), 8'($urandom));
      total++;
      if (gnt0 !== e_g0 || gnt1 !== e_g1) begin
        bad++;
        $display("FAIL rand_gnt: i=%0d gnt=%b%b required %b%b", i, gnt1, gnt0, e_g1, e_g0);
      end
      total++;
      if (ram_rw !== e_rw || ram_w_addr !== e_addr || ram_r_addr !== e_addr ||
          ram_indata !== e_ind) begin
        bad++;
        $display("FAIL rand_ram: i=%0d rw=%b wa=%0d ra=%0d in=%h required rw=%b a=%0d in=%h", i,
                 ram_rw, ram_w_addr, ram_r_addr, ram_indata, e_rw, e_addr, e_ind);
      end
      total++;
      if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1 || rdata0 !== e_rd0 || rdata1 !== e_rd1) begin
        bad++;
        $display("FAIL rand_rd: i=%0d rv=%b%b rd=%h/%h required rv=%b%b rd=%h/%h", i, rvalid1,
                 rvalid0, rdata1, rdata0, e_rv1, e_rv0, e_rd1, e_rd0);
      end
      advance();
    end
  endtask

  task automatic test_idle();
    bit saved_ptr;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
      advance();
    end
    saved_ptr = m_ptr;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
      total++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_rw !== 1'b0 || rvalid0 !== 1'b0 ||
          rvalid1 !== 1'b0) begin
        bad++;
        $display("FAIL idle: k=%0d gnt=%b%b rw=%b rv=%b%b required all 0", k, gnt1, gnt0,
                 ram_rw, rvalid1, rvalid0);
      end
      advance();
    end
    step(1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 5'd1, 8'd0);
    total++;
    if (gnt1 !== saved_ptr || gnt0 !== !saved_ptr) begin
      bad++;
      $display("FAIL idle_ptr: gnt=%b%b required winner client %0d", gnt1, gnt0, saved_ptr);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
      advance();
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    m_ptr   = 1'b0;
    m_rd[0] = 8'd0;
    m_rd[1] = 8'd0;
    for (int a = 0; a < 32; a++) m_mem[a] = 8'd0;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    we0 = 1'b0;
    we1 = 1'b0;
    addr0 = 5'd0;
    addr1 = 5'd0;
    wdata0 = 8'd0;
    wdata1 = 8'd0;

    test_reset();
    test_prefill();
    test_write_read();
    test_contention();
    test_cross();
    test_stream();
    test_reset_mid();
    test_random();
    test_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
